// File: rtl/v_alu_writeback.sv
// ALU result writeback: packs compare-mask beats into 64-bit words and
// queues all writes to the register file through a small FIFO.
module v_alu_writeback #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int SEW_WIDTH  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_vec,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [SEW_WIDTH-1:0]    in_sew,
    input  logic                    in_mask_op,
    input  logic                    in_last,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    busy,
    output logic                    err
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, PACK} pack_state_t;

    pack_state_t           state_q, state_d;
    logic [6:0]            cnt_q, cnt_d;
    logic [63:0]           acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  err_q;

    logic [3:0]            b;
    logic [7:0]            mbits;
    logic [6:0]            base_cnt, sum_cnt, fin_cnt, nbytes;
    logic [63:0]           base_acc, packed_acc;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  fill, proto_err;
    logic [BE_W-1:0]       pack_be;

    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [BE_W-1:0]       push_be;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [BE_W-1:0]       mem_be   [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic                  pop, full, push_ok, drop;

    // A beat arriving in IDLE starts from an empty accumulator, so the
    // deposit below works identically for the first and later beats.
    always_comb begin
        b          = 4'd8 >> in_sew;
        mbits      = in_vec[7:0] & (8'hFF >> (4'd8 - b));
        base_cnt   = (state_q == PACK) ? cnt_q   : '0;
        base_acc   = (state_q == PACK) ? acc_q   : '0;
        base_addr  = (state_q == PACK) ? waddr_q : in_addr;
        sum_cnt    = base_cnt + 7'(b);
        packed_acc = base_acc | (64'(mbits) << base_cnt);
        fill       = sum_cnt >= 7'd64;
        fin_cnt    = fill ? 7'd64 : sum_cnt;
        nbytes     = (fin_cnt + 7'd7) >> 3;
        pack_be    = '0;
        for (int unsigned k = 0; k < BE_W; k++) begin
            pack_be[k] = k < 32'(nbytes);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        waddr_d   = waddr_q;
        proto_err = 1'b0;
        push      = 1'b0;
        push_data = '0;
        push_addr = '0;
        push_be   = '0;
        if (in_valid) begin
            if (!in_mask_op) begin
                push      = 1'b1;
                push_data = in_vec;
                push_addr = in_addr;
                push_be   = '1;
                proto_err = (state_q == PACK);
                state_d   = IDLE;
                cnt_d     = '0;
                acc_d     = '0;
            end else if (fill || in_last) begin
                push      = 1'b1;
                push_data = DATA_WIDTH'(packed_acc);
                push_addr = base_addr;
                push_be   = pack_be;
                state_d   = IDLE;
                cnt_d     = '0;
                acc_d     = '0;
            end else begin
                state_d   = PACK;
                cnt_d     = sum_cnt;
                acc_d     = packed_acc;
                waddr_d   = base_addr;
            end
        end
    end

    assign pop     = wr_valid & wr_ready;
    assign full    = count_q == CW'(FIFO_DEPTH);
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            waddr_q <= '0;
            err_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            waddr_q <= waddr_d;
            err_q   <= err_q | proto_err | drop;
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop)     rptr_q <= rptr_q + PW'(1);
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (!push_ok && pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wptr_q] <= push_data;
            mem_addr[wptr_q] <= push_addr;
            mem_be[wptr_q]   <= push_be;
        end
    end

    // Storage is not reset; outputs are gated so they read zero when empty.
    assign wr_valid = count_q != '0;
    assign wr_data  = wr_valid ? mem_data[rptr_q] : '0;
    assign wr_addr  = wr_valid ? mem_addr[rptr_q] : '0;
    assign wr_be    = wr_valid ? mem_be[rptr_q]   : '0;
    assign busy     = (state_q == PACK) | wr_valid;
    assign err      = err_q;

endmodule

// File: tb/tb_v_alu_writeback.sv
// Randomized self-checking bench for v_alu_writeback against a queue-based
// reference model, plus directed scenarios with constant expectations.
module tb_v_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_vec;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [1:0]  in_sew;
    logic        in_mask_op;
    logic        in_last;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic [31:0] wr_addr;
    logic [7:0]  wr_be;
    logic        busy;
    logic        err;

    v_alu_writeback #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(32),
        .SEW_WIDTH (2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_sew    (in_sew),
        .in_mask_op(in_mask_op),
        .in_last   (in_last),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [31:0] a;
        logic [7:0]  be;
    } wr_t;

    wr_t         q[$];
    bit          m_active;
    int          m_cnt;
    logic [63:0] m_acc;
    logic [31:0] m_addr;
    bit          m_err;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_cnt    = 0;
        m_acc    = '0;
        m_addr   = '0;
        m_err    = 0;
    endtask

    // Applies one clock edge's worth of behaviour to the model.
    task automatic model_step();
        wr_t e;
        bit  have = 0;
        bit  pop  = (q.size() > 0) && wr_ready;
        bit  dropped;
        if (in_valid) begin
            if (!in_mask_op) begin
                if (m_active) begin
                    m_err    = 1;
                    m_active = 0;
                end
                e.d = in_vec; e.a = in_addr; e.be = 8'hFF;
                have = 1;
            end else begin
                int b = 8 >> in_sew;
                if (!m_active) begin
                    m_active = 1;
                    m_cnt    = 0;
                    m_acc    = '0;
                    m_addr   = in_addr;
                end
                for (int i = 0; i < b; i++)
                    if (m_cnt + i < 64) m_acc[m_cnt + i] = in_vec[i];
                m_cnt += b;
                if (m_cnt >= 64 || in_last) begin
                    int nb = ((m_cnt > 64 ? 64 : m_cnt) + 7) / 8;
                    e.d = m_acc; e.a = m_addr; e.be = 8'((16'd1 << nb) - 1);
                    have     = 1;
                    m_active = 0;
                end
            end
        end
        dropped = have && (q.size() == 4) && !pop;
        if (dropped) m_err = 1;
        if (pop) void'(q.pop_front());
        if (have && !dropped) q.push_back(e);
    endtask

    task automatic check_outputs();
        bit ev = q.size() != 0;
        check("wr_valid", wr_valid, ev);
        if (ev) begin
            check("wr_data", wr_data, q[0].d);
            check("wr_addr", wr_addr, q[0].a);
            check("wr_be", wr_be, q[0].be);
        end
        check("busy", busy, m_active || ev);
        check("err", err, m_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, wr_valid, 0);
        check({tag, "_data"}, wr_data, 0);
        check({tag, "_addr"}, wr_addr, 0);
        check({tag, "_be"}, wr_be, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic cycle(input bit v, input logic [63:0] vec, input logic [31:0] addr,
                         input logic [1:0] sew, input bit m, input bit last, input bit rdy);
        in_valid = v; in_vec = vec; in_addr = addr; in_sew = sew;
        in_mask_op = m; in_last = last; wr_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        cycle(0, {$urandom, $urandom}, $urandom, 2'($urandom), 1'($urandom), 1'($urandom), rdy);
    endtask

    task automatic rand_inputs();
        in_valid = 1'($urandom); in_vec = {$urandom, $urandom}; in_addr = $urandom;
        in_sew = 2'($urandom); in_mask_op = 1'($urandom); in_last = 1'($urandom);
        wr_ready = 1'($urandom);
    endtask

    // Entered just after a falling edge; leaves released at a falling edge.
    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        model_reset();
        check_zero("rst_async");
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            @(negedge clk);
            check_zero("rst_hold");
        end
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    logic [63:0] dv [5];
    logic [63:0] tmp;

    initial begin
        rst = 1'b0; in_vec = '0; in_valid = 0; in_addr = '0; in_sew = '0;
        in_mask_op = 0; in_last = 0; wr_ready = 0;
        @(negedge clk);
        do_reset(3);
        for (int i = 0; i < 3; i++) idle(1);
        check("idle_after_rst", wr_valid, 0);

        // Non-mask beat, written for exactly one cycle.
        cycle(1, 64'h1122334455667788, 32'h40, 2'd0, 0, 0, 1);
        check("nm_data", wr_data, 64'h1122334455667788);
        check("nm_addr", wr_addr, 32'h40);
        check("nm_be", wr_be, 8'hFF);
        idle(1);
        check("nm_one_cycle", wr_valid, 0);

        // sew=0: eight byte-wide mask beats fill one word.
        for (int i = 1; i <= 8; i++) begin
            tmp = {$urandom, $urandom};
            tmp[7:0] = 8'(i);
            cycle(1, tmp, (i == 1) ? 32'h100 : $urandom, 2'd0, 1, 0, 1);
        end
        check("sew0_valid", wr_valid, 1);
        check("sew0_data", wr_data, 64'h0807060504030201);
        check("sew0_addr", wr_addr, 32'h100);
        check("sew0_be", wr_be, 8'hFF);
        idle(1);

        // sew=3: three single-bit beats terminated by in_last.
        for (int i = 0; i < 3; i++) begin
            tmp = {$urandom, $urandom};
            tmp[0] = (i != 1);
            cycle(1, tmp, (i == 0) ? 32'h200 : $urandom, 2'd3, 1, i == 2, 1);
        end
        check("sew3_data", wr_data, 64'h5);
        check("sew3_be", wr_be, 8'h01);
        check("sew3_addr", wr_addr, 32'h200);
        idle(1);
        check("sew3_busy_after_pop", busy, 0);

        // Overflow: fifth write with a full buffer and no pop is dropped.
        for (int i = 0; i < 5; i++) begin
            dv[i] = {$urandom, $urandom};
            cycle(1, dv[i], 32'h1000 + 32'(i * 8), 2'($urandom), 0, 0, 0);
        end
        check("ovf_err", err, 1);
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain", wr_data, dv[k]);
            idle(1);
        end
        check("ovf_empty", wr_valid, 0);

        // Protocol error: non-mask beat mid-pack discards the partial word.
        do_reset(2);
        idle(1);
        for (int i = 0; i < 3; i++) cycle(1, {$urandom, $urandom}, 32'h300, 2'd0, 1, 0, 1);
        tmp = {$urandom, $urandom};
        cycle(1, tmp, 32'h340, 2'($urandom), 0, 0, 1);
        check("perr_err", err, 1);
        check("perr_data", wr_data, tmp);
        check("perr_addr", wr_addr, 32'h340);
        idle(1);
        check("perr_single", wr_valid, 0);

        // Reset in the middle of packing leaves nothing behind.
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1, {$urandom, $urandom}, 32'h400, 2'd0, 1, 0, 1);
        check("midpack_busy", busy, 1);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("midpack_no_write", wr_valid, 0);
        end

        // Randomized traffic.
        for (int blk = 0; blk < 10; blk++) begin
            do_reset(1);
            for (int n = 0; n < 200; n++)
                cycle(($urandom % 4) != 0, {$urandom, $urandom}, $urandom, 2'($urandom),
                      ($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
